oam_dma_ctrl: RTL and testbench
===============================

Name: oam_dma_ctrl

Overview:
- NES sprite-DMA sequencer for the 6502 CPU bus; watches CPU writes to $4014.
- On a trigger it halts the CPU via cpu_rdy, takes ownership of the CPU memory bus and copies 256 bytes from page $XX00-$XXFF into PPU OAM.
- Sits between cpu6502 core, CPU memory mux and PPU OAM port; the top-level mux selects DMA addresses while dma_grant=1.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address whose write triggers DMA; written data = source page.
- OAMADDR_REG_ADDR, 16'h2003, PPU OAMADDR register address; used only with the optional feature.
- XFER_LEN, 256, bytes per transfer; power of 2, ≤256.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- cpu_addr  in  16  CPU bus address.
- cpu_wdata  in  8  CPU write data.
- cpu_we  in  1  CPU write strobe, one cycle per write.
- mem_rdata  in  8  CPU-bus memory read data; valid the cycle after bus_re.
- cpu_rdy  out  1  1 = CPU may run; 0 = CPU holds all state.
- dma_grant  out  1  1 = top mux drives bus from bus_addr/bus_re.
- bus_addr  out  16  DMA read address.
- bus_re  out  1  DMA read strobe.
- oam_addr  out  8  OAM byte index.
- oam_wdata  out  8  OAM write data.
- oam_we  out  1  OAM write strobe.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Clock CLK; reset synchronous active-high on RESET. Reset dominates every state, including mid-transfer: state=IDLE, cpu_rdy=1; dma_grant, bus_re, oam_we, busy, done=0; bus_addr=0, oam_addr=0, page=0, idx=0, parity=0. No OAM write happens in the reset cycle.
- parity: free-running 1-bit toggle every cycle after reset; models CPU get/put alignment.
- Trigger: state==IDLE && cpu_we && cpu_addr==DMA_REG_ADDR → page<=cpu_wdata, idx<=0, next state HALT. A trigger while not IDLE is ignored (CPU halted; defensive).
- States and per-state outputs (all outputs registered except oam_wdata):
  - IDLE: cpu_rdy=1, busy=0.
  - HALT (1 cycle): cpu_rdy=0, busy=1. Lets the triggering write retire. Next state ALIGN if parity==1, else READ.
  - ALIGN (1 cycle): cpu_rdy=0, busy=1, dma_grant=0. Next state READ.
  - READ: dma_grant=1, bus_re=1, bus_addr={page,idx}. Next state WRITE.
  - WRITE: dma_grant=1, oam_we=1, oam_addr=idx (plus offset when the optional feature is enabled), oam_wdata=mem_rdata (combinational pass). idx<=idx+1. If idx==XFER_LEN-1, next state DONE, else READ.
  - DONE (1 cycle): done=1, busy=0, cpu_rdy=1, dma_grant=0. Next state IDLE.
- Timing: with trigger at cycle T, cpu_rdy is low from T+1 through T+513 (parity 0) or T+514 (parity 1), i.e. 513 or 514 cycles for XFER_LEN=256.
- idx is 8-bit and wraps; bus_addr never crosses the page (page $FF reads $FF00-$FFFF).
- oam_addr arithmetic is 8-bit modulo 256.
- CPU writes seen while not IDLE (none expected) do not alter page.

Optional Feature:
- Macro OAM_DMA_OAMADDR_OFFSET_EN.
- Defined:
  - An 8-bit oam_base register is loaded whenever cpu_we && cpu_addr==OAMADDR_REG_ADDR while IDLE; it resets to 0.
  - oam_addr=(oam_base+idx) mod 256, wrapping past 255.
  - oam_base is not modified by the transfer.
- Undefined: oam_base logic is absent and oam_addr=idx.

Test Plan:
- Reset, write $02 to $4014 at an even-parity cycle, memory[$02nn]=nn^$A5 → 256 oam_we pulses, OAM[i]=i^$A5; cpu_rdy low 513 cycles; done pulses once; busy low afterwards.
- Same trigger at an odd-parity cycle → one ALIGN cycle; cpu_rdy low 514 cycles; data identical.
- Page $FF trigger → bus_addr spans $FF00-$FFFF only; last read at $FFFF; no read at $0000.
- Assert RESET during WRITE at idx=$40 → next cycle IDLE, cpu_rdy=1, oam_we=0; a new $4014 write of $03 restarts at idx=0 from $0300.
- Write to $4015 and a read of $4014 → no trigger; cpu_rdy stays 1.
- With OAM_DMA_OAMADDR_OFFSET_EN: write $F0 to $2003, then $02 to $4014 → first oam_addr=$F0; byte 16 lands at oam_addr $00; OAM[(i+$F0)&$FF]=mem[$0200+i].

Source files
------------

// File: rtl/oam_dma_ctrl.sv
// NES sprite DMA sequencer: a write to $4014 halts the CPU and copies one page into OAM.
// Optional OAMADDR-relative destination is built when OAM_DMA_OAMADDR_OFFSET_EN is defined.
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR     = 16'h4014,
    parameter logic [15:0] OAMADDR_REG_ADDR = 16'h2003,
    parameter int          XFER_LEN         = 256
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    input  logic [7:0]  mem_rdata,
    output logic        cpu_rdy,
    output logic        dma_grant,
    output logic [15:0] bus_addr,
    output logic        bus_re,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        oam_we,
    output logic        busy,
    output logic        done
);

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_n;
    logic        parity;
    logic [7:0]  page;
    logic [7:0]  page_n;
    logic [7:0]  idx;
    logic [7:0]  idx_n;
    logic [7:0]  oam_off;

    logic        cpu_rdy_n;
    logic        dma_grant_n;
    logic [15:0] bus_addr_n;
    logic        bus_re_n;
    logic [7:0]  oam_addr_n;
    logic        oam_we_n;
    logic        busy_n;
    logic        done_n;

`ifdef OAM_DMA_OAMADDR_OFFSET_EN
    logic [7:0] oam_base;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            oam_base <= 8'h00;
        end else if (state == S_IDLE && cpu_we &&
                     cpu_addr == OAMADDR_REG_ADDR) begin
            oam_base <= cpu_wdata;
        end
    end

    assign oam_off = oam_base;
`else
    logic unused_oamaddr_reg;

    assign unused_oamaddr_reg = ^OAMADDR_REG_ADDR;
    assign oam_off = 8'h00;
`endif

    // Read data arrives the cycle after bus_re, i.e. during WRITE.
    assign oam_wdata = mem_rdata;

    always_comb begin
        state_n = state;
        page_n  = page;
        idx_n   = idx;
        unique case (state)
            S_IDLE: begin
                if (cpu_we && cpu_addr == DMA_REG_ADDR) begin
                    page_n  = cpu_wdata;
                    idx_n   = 8'h00;
                    state_n = S_HALT;
                end
            end
            S_HALT:  state_n = parity ? S_ALIGN : S_READ;
            S_ALIGN: state_n = S_READ;
            S_READ:  state_n = S_WRITE;
            S_WRITE: begin
                idx_n   = idx + 8'h01;
                state_n = (idx == LAST_IDX) ? S_DONE : S_READ;
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the next state.
        cpu_rdy_n   = (state_n == S_IDLE) || (state_n == S_DONE);
        busy_n      = state_n inside {S_HALT, S_ALIGN, S_READ, S_WRITE};
        dma_grant_n = (state_n == S_READ) || (state_n == S_WRITE);
        bus_re_n    = (state_n == S_READ);
        oam_we_n    = (state_n == S_WRITE);
        done_n      = (state_n == S_DONE);
        bus_addr_n  = (state_n == S_READ) ? {page_n, idx_n} : bus_addr;
        oam_addr_n  = (state_n == S_WRITE) ? oam_off + idx_n : oam_addr;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= S_IDLE;
            parity    <= 1'b0;
            page      <= 8'h00;
            idx       <= 8'h00;
            cpu_rdy   <= 1'b1;
            dma_grant <= 1'b0;
            bus_addr  <= 16'h0000;
            bus_re    <= 1'b0;
            oam_addr  <= 8'h00;
            oam_we    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            parity    <= ~parity;
            page      <= page_n;
            idx       <= idx_n;
            cpu_rdy   <= cpu_rdy_n;
            dma_grant <= dma_grant_n;
            bus_addr  <= bus_addr_n;
            bus_re    <= bus_re_n;
            oam_addr  <= oam_addr_n;
            oam_we    <= oam_we_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl: random memory, directed triggers, reference OAM image.
// Expected OAM destination depends on OAM_DMA_OAMADDR_OFFSET_EN.
module tb_oam_dma_ctrl;

    logic        CLK;
    logic        RESET;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_we;
    logic [7:0]  mem_rdata;
    logic        cpu_rdy;
    logic        dma_grant;
    logic [15:0] bus_addr;
    logic        bus_re;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        oam_we;
    logic        busy;
    logic        done;

    oam_dma_ctrl dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .mem_rdata (mem_rdata),
        .cpu_rdy   (cpu_rdy),
        .dma_grant (dma_grant),
        .bus_addr  (bus_addr),
        .bus_re    (bus_re),
        .oam_addr  (oam_addr),
        .oam_wdata (oam_wdata),
        .oam_we    (oam_we),
        .busy      (busy),
        .done      (done)
    );

    logic [7:0] mem [0:65535];
    logic [7:0] oam_cap [0:255];
    logic [7:0] base_m;
    int         ecount;
    int         n_cmp;
    int         n_bad;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Cycles since reset; its LSB is the CPU get/put phase.
    always @(posedge CLK) begin
        if (RESET) ecount <= 0;
        else       ecount <= ecount + 1;
    end

    // Memory behind the CPU bus: synchronous read, one cycle latency.
    always @(posedge CLK) begin
        if (dma_grant && bus_re) mem_rdata <= mem[bus_addr];
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_we    = 1'b1;
        @(negedge CLK);
        cpu_we    = 1'b0;
        cpu_addr  = 16'h0000;
    endtask

    task automatic set_base(input logic [7:0] d);
        cpu_write(16'h2003, d);
`ifdef OAM_DMA_OAMADDR_OFFSET_EN
        base_m = d;
`else
        base_m = 8'h00;
`endif
    endtask

    task automatic run_xfer(input logic [7:0] pg, input int want_align);
        int low, nogrant, nwe, ndone, nrd, nout, bad, exp_low;
        logic [15:0] first_rd, last_rd;
        logic [7:0]  first_oa, k8;
        low = 0; nogrant = 0; nwe = 0; ndone = 0;
        nrd = 0; nout = 0; bad = 0;
        first_rd = 16'h0; last_rd = 16'h0; first_oa = 8'h0;
        for (int k = 0; k < 4; k++) begin
            if ((ecount + 1) % 2 == want_align) break;
            @(negedge CLK);
        end
        exp_low = 513 + ((ecount + 1) % 2);
        cpu_write(16'h4014, pg);
        for (int c = 0; c < 700; c++) begin
            if (!cpu_rdy) begin
                low++;
                if (!dma_grant) nogrant++;
            end
            if (bus_re) begin
                if (nrd == 0) first_rd = bus_addr;
                last_rd = bus_addr;
                nrd++;
                if (bus_addr[15:8] != pg) nout++;
            end
            if (oam_we) begin
                if (nwe == 0) first_oa = oam_addr;
                oam_cap[oam_addr] = oam_wdata;
                nwe++;
            end
            if (done) begin
                ndone++;
                chk("done_busy", {31'b0, busy}, 32'd0);
                chk("done_rdy", {31'b0, cpu_rdy}, 32'd1);
                break;
            end
            @(negedge CLK);
        end
        chk("rdy_low_cycles", low, exp_low);
        chk("halt_align_cycles", nogrant, exp_low - 512);
        chk("oam_we_count", nwe, 256);
        chk("done_count", ndone, 1);
        chk("read_count", nrd, 256);
        chk("reads_off_page", nout, 0);
        chk("first_read", {16'h0, first_rd}, {16'h0, pg, 8'h00});
        chk("last_read", {16'h0, last_rd}, {16'h0, pg, 8'hff});
        chk("first_oam_addr", {24'h0, first_oa}, {24'h0, base_m});
        @(negedge CLK);
        chk("post_busy", {31'b0, busy}, 32'd0);
        chk("post_done", {31'b0, done}, 32'd0);
        chk("post_rdy", {31'b0, cpu_rdy}, 32'd1);
        for (int i = 0; i < 256; i++) begin
            k8 = 8'(i);
            if (oam_cap[8'(base_m + k8)] !== mem[{pg, k8}]) bad++;
        end
        chk("oam_image_bad", bad, 0);
    endtask

    task automatic check_idle_reset(input string tag);
        chk({tag, "_rdy"}, {31'b0, cpu_rdy}, 32'd1);
        chk({tag, "_grant"}, {31'b0, dma_grant}, 32'd0);
        chk({tag, "_re"}, {31'b0, bus_re}, 32'd0);
        chk({tag, "_we"}, {31'b0, oam_we}, 32'd0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_done"}, {31'b0, done}, 32'd0);
        chk({tag, "_baddr"}, {16'h0, bus_addr}, 32'd0);
        chk({tag, "_oaddr"}, {24'h0, oam_addr}, 32'd0);
    endtask

    initial begin
        logic [7:0] k8;
        int found;
        n_cmp = 0;
        n_bad = 0;
        base_m = 8'h00;
        mem_rdata = 8'h00;
        cpu_addr = 16'h0;
        cpu_wdata = 8'h0;
        cpu_we = 1'b0;
        RESET = 1'b1;
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        for (int i = 0; i < 256; i++) begin
            k8 = 8'(i);
            mem[{8'h02, k8}] = k8 ^ 8'ha5;
        end
        for (int i = 0; i < 256; i++) oam_cap[i] = 8'h00;

        repeat (3) @(negedge CLK);
        check_idle_reset("reset");
        RESET = 1'b0;
        @(negedge CLK);

        // Near-miss accesses must not start a transfer.
        cpu_write(16'h4015, 8'h02);
        cpu_addr = 16'h4014;
        cpu_wdata = 8'h02;
        @(negedge CLK);
        cpu_addr = 16'h0000;
        for (int c = 0; c < 5; c++) begin
            chk("notrig_rdy", {31'b0, cpu_rdy}, 32'd1);
            chk("notrig_busy", {31'b0, busy}, 32'd0);
            @(negedge CLK);
        end

        run_xfer(8'h02, 0);
        run_xfer(8'h02, 1);
        run_xfer(8'hff, 0);

        // Reset in the middle of a transfer, then restart.
        cpu_write(16'h4014, 8'h05);
        found = 0;
        for (int c = 0; c < 300; c++) begin
            if (oam_we && oam_addr == 8'(base_m + 8'h40)) begin
                found = 1;
                break;
            end
            @(negedge CLK);
        end
        chk("reach_idx40", found, 1);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        base_m = 8'h00;
        check_idle_reset("midreset");
        @(negedge CLK);
        run_xfer(8'h03, 1);

        set_base(8'hf0);
        run_xfer(8'h02, 0);

        for (int r = 0; r < 3; r++) begin
            set_base(8'($urandom));
            run_xfer(8'($urandom_range(0, 255)), int'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
